// File: rtl/onewire_slave.sv
// onewire_slave: bit-level 1-wire responder with presence reply and
// LSB-first byte receive/transmit over an open-drain line.
module onewire_slave #(
    parameter int CNT_W    = 16,
    parameter int T_SAMPLE = 983,
    parameter int T_HOLD   = 983,
    parameter int T_RST    = 13107,
    parameter int T_PDLY   = 983,
    parameter int T_PRES   = 3932
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       owr_i,
    output logic       owr_e,
    output logic       rst_det,
    output logic [7:0] rx_dat,
    output logic       rx_vld,
    input  logic [7:0] tx_dat,
    input  logic       tx_ld,
    output logic       tx_bsy
);
    typedef enum logic [2:0] {
        S_IDLE, S_SLOT, S_RST_WAIT, S_PDLY, S_PRES
    } state_t;

    localparam logic [CNT_W-1:0] C_SAMPLE   = CNT_W'(T_SAMPLE);
    localparam logic [CNT_W-1:0] C_HOLD     = CNT_W'(T_HOLD);
    localparam logic [CNT_W-1:0] C_RST      = CNT_W'(T_RST);
    localparam logic [CNT_W-1:0] C_PDLY_END = CNT_W'(T_PDLY - 1);
    localparam logic [CNT_W-1:0] C_PRES     = CNT_W'(T_PRES);
    // A low pulse shorter than this is noise, not a slot.
    localparam logic [CNT_W-1:0] C_GLITCH   = CNT_W'(T_SAMPLE / 8);

    state_t           r_state, w_nxt;
    logic             r_sync1, r_sync2, r_line_q;
    logic             w_line_s, w_fall, w_rise;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_rx_sr, r_tx_sr, w_rx_nxt;
    logic             r_rd_slot, r_drv;
    logic             w_drv0, w_ld_ok, w_sample, w_hold, w_tx_last;
    logic             r_rst_det, r_rx_vld, r_tx_bsy;
    logic [7:0]       r_rx_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_line_q <= 1'b1;
        end else begin
            r_sync1  <= owr_i;
            r_sync2  <= r_sync1;
            r_line_q <= r_sync2;
        end
    end

    assign w_line_s  = r_sync2;
    assign w_fall    = r_line_q & ~w_line_s;
    assign w_rise    = ~r_line_q & w_line_s;
    assign w_sample  = (r_state == S_SLOT) && (r_cnt == C_SAMPLE);
    assign w_hold    = (r_state == S_SLOT) && (r_cnt == C_HOLD);
    assign w_ld_ok   = tx_ld && (r_state == S_IDLE) && !r_tx_bsy;
    assign w_drv0    = r_tx_bsy ? ~r_tx_sr[r_bit_cnt]
                                : (tx_ld & ~tx_dat[0]);
    // bit_cnt has already advanced at the hold point if hold follows sample
    assign w_tx_last = (T_HOLD > T_SAMPLE) ? (r_bit_cnt == 3'd0)
                                           : (r_bit_cnt == 3'd7);

    always_comb begin
        w_rx_nxt            = r_rx_sr;
        w_rx_nxt[r_bit_cnt] = w_line_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_fall) w_nxt = S_SLOT;
            S_SLOT: begin
                if (w_rise && (r_cnt < C_GLITCH))
                    w_nxt = S_IDLE;
                else if (w_line_s && (r_cnt > C_SAMPLE))
                    w_nxt = S_IDLE;
                else if (!w_line_s && (r_cnt >= C_RST))
                    w_nxt = S_RST_WAIT;
            end
            S_RST_WAIT: if (w_line_s) w_nxt = S_PDLY;
            S_PDLY: if (r_cnt == C_PDLY_END) w_nxt = S_PRES;
            S_PRES: if (r_cnt == C_PRES) w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        owr_e = 1'b0;
        case (r_state)
            S_IDLE:  owr_e = w_fall & w_drv0;
            S_SLOT:  owr_e = r_drv && (r_cnt < C_HOLD);
            S_PRES:  owr_e = (r_cnt < C_PRES);
            default: owr_e = 1'b0;
        endcase
    end

    // Counter is 0 in the falling-edge cycle, so slot timing starts there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_cnt <= (w_nxt == S_SLOT) ? CNT_W'(1) : '0;
        end else if (w_nxt != r_state && w_nxt != S_RST_WAIT) begin
            r_cnt <= '0;
        end else if (!(&r_cnt)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_rx_sr   <= '0;
            r_tx_sr   <= '0;
            r_rx_dat  <= '0;
            r_rd_slot <= 1'b0;
            r_drv     <= 1'b0;
            r_rst_det <= 1'b0;
            r_rx_vld  <= 1'b0;
            r_tx_bsy  <= 1'b0;
        end else begin
            r_rst_det <= 1'b0;
            r_rx_vld  <= 1'b0;
            if (w_ld_ok) begin
                r_tx_sr   <= tx_dat;
                r_tx_bsy  <= 1'b1;
                r_bit_cnt <= '0;
            end
            if (r_state == S_IDLE && w_fall) begin
                r_rd_slot <= r_tx_bsy | tx_ld;
                r_drv     <= w_drv0;
            end
            if (w_sample) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (!r_rd_slot) begin
                    r_rx_sr <= w_rx_nxt;
                    if (r_bit_cnt == 3'd7) begin
                        r_rx_dat <= w_rx_nxt;
                        r_rx_vld <= 1'b1;
                    end
                end
            end
            if (w_hold && r_rd_slot && w_tx_last)
                r_tx_bsy <= 1'b0;
            if (r_state == S_SLOT && w_nxt == S_RST_WAIT) begin
                r_bit_cnt <= '0;
                r_tx_bsy  <= 1'b0;
            end
            if (r_state == S_RST_WAIT && w_line_s)
                r_rst_det <= 1'b1;
        end
    end

    assign rst_det = r_rst_det;
    assign rx_dat  = r_rx_dat;
    assign rx_vld  = r_rx_vld;
    assign tx_bsy  = r_tx_bsy;
endmodule

// File: tb/tb_onewire_slave.sv
// tb_onewire_slave: directed vectors for the 1-wire responder, with
// timing scaled to 2 cycles per microsecond and a wired-AND line model.
module tb_onewire_slave;
    localparam int TS  = 60;
    localparam int TH  = 60;
    localparam int TR  = 800;
    localparam int TPD = 60;
    localparam int TPR = 240;

    localparam int W1_LOW = 12;
    localparam int W0_LOW = 120;
    localparam int SLOT_LEN = 140;
    localparam int RST_LOW = 1000;

    typedef struct {
        logic [7:0] wr;
        logic [7:0] exp;
    } wr_vec_t;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] mask;
        bit         coinc;
    } rd_vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_low = 1'b0;
    logic       tx_ld = 1'b0;
    logic [7:0] tx_dat = 8'h00;
    logic       owr_i, owr_e, rst_det, rx_vld, tx_bsy;
    logic [7:0] rx_dat;

    assign owr_i = ~(m_low | owr_e);

    always #5 clk = ~clk;

    onewire_slave #(
        .CNT_W(16), .T_SAMPLE(TS), .T_HOLD(TH),
        .T_RST(TR), .T_PDLY(TPD), .T_PRES(TPR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .owr_i(owr_i),
        .owr_e(owr_e), .rst_det(rst_det),
        .rx_dat(rx_dat), .rx_vld(rx_vld),
        .tx_dat(tx_dat), .tx_ld(tx_ld), .tx_bsy(tx_bsy)
    );

    int cyc = 0;
    int vld_n = 0, vld_cyc = 0, rd_n = 0, rd_cyc = 0;
    int hi_n = 0, rise_cyc = 0, fall_cyc = 0, bsy_fall = 0;
    logic [7:0] vld_dat = 8'h00;
    logic owr_q = 1'b0, bsy_q = 1'b0;
    int n_chk = 0, n_fail = 0;
    int slot_start = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        owr_q <= owr_e;
        bsy_q <= tx_bsy;
        if (owr_e) hi_n <= hi_n + 1;
        if (owr_e && !owr_q) rise_cyc <= cyc;
        if (!owr_e && owr_q) fall_cyc <= cyc;
        if (bsy_q && !tx_bsy) bsy_fall <= cyc;
        if (rx_vld) begin
            vld_n   <= vld_n + 1;
            vld_cyc <= cyc;
            vld_dat <= rx_dat;
        end
        if (rst_det) begin
            rd_n   <= rd_n + 1;
            rd_cyc <= cyc;
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic slot(input int low, input int len, input int ld_at);
        slot_start = cyc;
        for (int k = 0; k < len; k++) begin
            m_low = (k < low);
            tx_ld = (k == ld_at);
            @(posedge clk);
            #1;
        end
        m_low = 1'b0;
        tx_ld = 1'b0;
    endtask

    task automatic load(input logic [7:0] b);
        tx_dat = b;
        tx_ld  = 1'b1;
        @(posedge clk);
        #1;
        tx_ld  = 1'b0;
    endtask

    task automatic reset_pulse(input string nm);
        int r0, h0, rel;
        r0 = rd_n;
        h0 = hi_n;
        slot(RST_LOW, RST_LOW, -1);
        rel = slot_start + RST_LOW;
        repeat (400) @(posedge clk);
        #1;
        check({nm, "_rst_det_cnt"}, rd_n - r0, 1);
        check({nm, "_rst_det_cyc"}, rd_cyc, rel + 3);
        check({nm, "_pres_start"}, rise_cyc, rel + 3 + TPD);
        check({nm, "_pres_len"}, hi_n - h0, TPR);
        check({nm, "_pres_end"}, fall_cyc, rel + 3 + TPD + TPR);
    endtask

    task automatic write_byte(input logic [7:0] b,
                              input logic [7:0] exp,
                              input string nm);
        int v0;
        v0 = vld_n;
        for (int i = 0; i < 8; i++)
            slot(b[i] ? W1_LOW : W0_LOW, SLOT_LEN, -1);
        check({nm, "_vld_cnt"}, vld_n - v0, 1);
        check({nm, "_rx_dat"}, int'(vld_dat), int'(exp));
        check({nm, "_vld_cyc"}, vld_cyc, slot_start + TS + 3);
    endtask

    task automatic read_byte(input logic [7:0] b,
                             input logic [7:0] mask,
                             input bit coinc,
                             input string nm);
        int h0, v0;
        v0 = vld_n;
        tx_dat = b;
        if (!coinc) begin
            load(b);
            check({nm, "_bsy_set"}, int'(tx_bsy), 1);
        end
        for (int i = 0; i < 8; i++) begin
            h0 = hi_n;
            slot(W1_LOW, SLOT_LEN, (coinc && i == 0) ? 2 : -1);
            check($sformatf("%s_slot%0d_pull", nm, i),
                  hi_n - h0, mask[i] ? TH : 0);
            if (i == 2) load(~b);
        end
        check({nm, "_bsy_clr"}, int'(tx_bsy), 0);
        check({nm, "_bsy_fall"}, bsy_fall, slot_start + TH + 3);
        check({nm, "_no_vld"}, vld_n - v0, 0);
    endtask

    initial begin
        wr_vec_t wr_tab[3];
        rd_vec_t rd_tab[3];
        int v0;

        wr_tab[0] = '{wr: 8'hA5, exp: 8'hA5};
        wr_tab[1] = '{wr: 8'h00, exp: 8'h00};
        wr_tab[2] = '{wr: 8'h3F, exp: 8'h3F};

        rd_tab[0] = '{tx: 8'h3C, mask: 8'hC3, coinc: 1'b0};
        rd_tab[1] = '{tx: 8'h96, mask: 8'h69, coinc: 1'b0};
        rd_tab[2] = '{tx: 8'hA6, mask: 8'h59, coinc: 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_owr_e", int'(owr_e), 0);
        check("rst_rst_det", int'(rst_det), 0);
        check("rst_rx_vld", int'(rx_vld), 0);
        check("rst_rx_dat", int'(rx_dat), 0);
        check("rst_tx_bsy", int'(tx_bsy), 0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        reset_pulse("t1");

        for (int i = 0; i < 3; i++)
            write_byte(wr_tab[i].wr, wr_tab[i].exp,
                       $sformatf("wr%0d", i));

        for (int i = 0; i < 3; i++)
            read_byte(rd_tab[i].tx, rd_tab[i].mask, rd_tab[i].coinc,
                      $sformatf("rd%0d", i));

        v0 = vld_n;
        slot(W1_LOW, SLOT_LEN, -1);
        slot(W0_LOW, SLOT_LEN, -1);
        slot(W1_LOW, SLOT_LEN, -1);
        slot(W1_LOW, SLOT_LEN, -1);
        reset_pulse("t4");
        check("t4_no_vld", vld_n - v0, 0);
        write_byte(8'h5A, 8'h5A, "t4_wr");

        slot(2, 30, -1);
        write_byte(8'hFF, 8'hFF, "t5_wr");

        slot(RST_LOW, RST_LOW, -1);
        for (int k = 0; k < 300 && !owr_e; k++) begin
            @(posedge clk);
            #1;
        end
        check("t6_pres_on", int'(owr_e), 1);
        repeat (50) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_async_owr_e", int'(owr_e), 0);
        check("t6_async_rx_dat", int'(rx_dat), 0);
        check("t6_async_bsy", int'(tx_bsy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        reset_pulse("t6");
        write_byte(8'hC3, 8'hC3, "t6_wr");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
